digit_serial_subtractor: RTL and testbench
==========================================

Name: digit_serial_subtractor

Overview:
- Parametrised multi-cycle N-bit subtractor computing D = A − B − Bin, DIGIT bits per clock, LSB digit first.
- Successor to the single-bit half/full subtractor cells; the borrow chain is registered across cycles rather than rippled combinationally.
- Start/busy/done handshake; registered difference, borrow-out and signed-overflow flag.
- Used wherever a wide subtract must trade latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock; NDIG = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  minuend; captured at the accepted start edge.
- b  in  WIDTH  subtrahend; captured at the accepted start edge.
- bin  in  1  borrow-in; captured at the accepted start edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse: result valid.
- d  out  WIDTH  difference (a − b − bin) mod 2^WIDTH.
- bout  out  1  borrow out of the MSB; 1 means unsigned a < b + bin.
- ovf  out  1  signed overflow: borrow into MSB XOR bout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0; done=0; d=0; bout=0; ovf=0; internal shift registers, borrow register and digit counter all cleared. Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge t:
  - latch a, b into shift registers; borrow register ← bin; counter ← 0; busy ← 1; state → RUN.
- RUN, every edge:
  - subtract the low DIGIT bits of the A/B shift registers with the current borrow.
  - shift both operand registers right by DIGIT.
  - shift the DIGIT result bits into the top of the result shift register.
  - borrow register ← digit borrow-out; counter += 1.
- Final RUN edge (counter == NDIG−1), i.e. edge t+NDIG:
  - d ← full result; bout ← final borrow; ovf ← borrow into bit WIDTH−1 XOR final borrow.
  - done ← 1; busy ← 0; state → IDLE.
- done is cleared at the next edge.
- Latency: done is high during the cycle after edge t+NDIG. busy is high for exactly NDIG cycles.
- d, bout and ovf hold their values until the next done; they do not change while busy.
- start while busy: ignored, with no effect on the operation in progress.
- start in the done cycle: accepted (state is IDLE), giving back-to-back operation with a throughput of one result per NDIG+1 cycles.
- a/b/bin may change freely after the accepting edge.
- DIGIT=WIDTH (NDIG=1): single RUN cycle; the same rules apply.
- Counter width: clog2(NDIG), minimum 1 bit.
- Width arithmetic: all subtraction is modulo 2^DIGIT per digit with an explicit borrow, with no sign extension. ovf treats a, b and d as two's complement.

Decomposition:
- Shared package sub_pkg:
  - state enum {IDLE, RUN}.
  - function computing counter width from NDIG.
- Sub-module digit_subtractor: combinational DIGIT-bit ripple of full-subtractor cells.
  - Inputs: x[DIGIT], y[DIGIT], bi.
  - Outputs: diff[DIGIT], bo, b_msb (borrow into the top bit, used for ovf).
- Top level holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, DIGIT=1: a=5, b=3, bin=0, start pulse at edge t → busy for 8 cycles; done at cycle t+8; d=0x02, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 → d=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 → d=0x7F, bout=0, ovf=1.
- a=0x10, b=0x0F, bin=1 → d=0x00, bout=0, ovf=0. Also a=0x7F, b=0xFF, bin=0 → d=0x80, bout=1, ovf=1.
- Handshake:
  - start held high and a changed during busy → first result unaffected, no restart.
  - New start in the done cycle (a=9, b=4) → second done exactly 9 cycles after the first, d=0x05.
- Reset mid-operation: rst_n low 3 cycles after start (asynchronously, between edges) → busy, done and d drop to 0 immediately; no done after release; next start computes correctly.
- WIDTH=8, DIGIT=4 and WIDTH=16, DIGIT=16:
  - 0x3C − 0x4D (bin=0) → d=0xEF, bout=1, done 2 cycles after start.
  - 0x8000 − 0x0001 → d=0x7FFF, ovf=1, done 1 cycle after start.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_e   : controller states (idle / running).
//   cnt_width : width of a counter that indexes ndig digits, at least one bit.
package sub_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_serial_subtractor_if.sv
// Handshake and data bundle for digit_serial_subtractor.
//   start, a, b, bin      : request and operands (master -> slave)
//   busy, done, d, bout,
//   ovf                   : status and result (slave -> master)
interface digit_serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );

endinterface

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple of full-subtractor cells: diff = x - y - bi.
//   x, y  : digit operands
//   bi    : borrow in
//   diff  : digit difference modulo 2^DIGIT
//   bo    : borrow out of the top bit
//   b_msb : borrow into the top bit (feeds the signed-overflow flag)
module digit_subtractor #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] diff,
    output logic             bo,
    output logic             b_msb
);

    logic [DIGIT:0] chain;

    assign chain[0] = bi;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign diff[i]    = x[i] ^ y[i] ^ chain[i];
        assign chain[i+1] = (~x[i] & y[i]) | (~x[i] & chain[i]) | (y[i] & chain[i]);
    end

    assign bo    = chain[DIGIT];
    assign b_msb = chain[DIGIT-1];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle subtractor: d = a - b - bin, DIGIT bits per clock, LSB digit first.
// The borrow is carried between cycles in a register instead of rippling across WIDTH.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of digit_serial_subtractor_if
//                (start/a/b/bin in; busy/done/d/bout/ovf out)
// WIDTH must be a multiple of DIGIT; an operation takes WIDTH/DIGIT busy cycles.
module digit_serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    digit_serial_subtractor_if.slave    bus
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = cnt_width(NDIG);
    localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_diff;
    logic             dig_bo;
    logic             dig_b_msb;
    logic [WIDTH-1:0] diff_ext;
    logic [WIDTH-1:0] r_next;

    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .bi    (brw_q),
        .diff  (dig_diff),
        .bo    (dig_bo),
        .b_msb (dig_b_msb)
    );

    // New digit enters at the top so that after NDIG shifts the LSB digit sits at bit 0.
    assign diff_ext = WIDTH'(dig_diff);
    assign r_next   = (r_q >> DIGIT) | (diff_ext << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    r_d     = '0;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                r_d   = r_next;
                brw_d = dig_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // On the last digit b_msb is the borrow into bit WIDTH-1.
                    d_d     = r_next;
                    bout_d  = dig_bo;
                    ovf_d   = dig_b_msb ^ dig_bo;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed bench for digit_serial_subtractor in three configurations:
// 8-bit/1-bit digits, 8-bit/4-bit digits and 16-bit/16-bit digits.
module tb_digit_serial_subtractor;

    logic clk;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;

    digit_serial_subtractor_if #(.WIDTH(8))  bus8 ();
    digit_serial_subtractor_if #(.WIDTH(8))  bus84 ();
    digit_serial_subtractor_if #(.WIDTH(16)) bus16 ();

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut84 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus84)
    );

    digit_serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Run one operation on the 8/1 instance; returns in the done cycle.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic eo);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!bus8.done && lat < 20) begin
            if (bus8.busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, " d"}, 32'(bus8.d), 32'(ed));
        check({tag, " bout"}, 32'(bus8.bout), 32'(eb));
        check({tag, " ovf"}, 32'(bus8.ovf), 32'(eo));
    endtask

    initial begin
        int lat;
        int seen_done;

        rst_n       = 1'b0;
        bus8.start  = 1'b0;  bus8.a  = '0; bus8.b  = '0; bus8.bin  = 1'b0;
        bus84.start = 1'b0;  bus84.a = '0; bus84.b = '0; bus84.bin = 1'b0;
        bus16.start = 1'b0;  bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;

        #12;
        check("reset busy", 32'(bus8.busy), 32'd0);
        check("reset done", 32'(bus8.done), 32'd0);
        check("reset d", 32'(bus8.d), 32'd0);
        check("reset bout", 32'(bus8.bout), 32'd0);
        check("reset ovf", 32'(bus8.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("5-3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("done pulse clears", 32'(bus8.done), 32'd0);
        check("d holds after done", 32'(bus8.d), 32'h02);

        run8("0-1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run8("80-1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run8("10-0F-1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        run8("7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start held high and operands changed while busy; then a new start in the done cycle.
        @(negedge clk);
        bus8.a     = 8'h20;
        bus8.b     = 8'h05;
        bus8.bin   = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.a = 8'hAA;
        bus8.b = 8'h11;
        lat = 0;
        while (!bus8.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held start latency", 32'(lat), 32'd8);
        check("held start d", 32'(bus8.d), 32'h1B);
        bus8.a = 8'h09;
        bus8.b = 8'h04;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        lat = 1;
        while (!bus8.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("back-to-back spacing", 32'(lat), 32'd9);
        check("back-to-back d", 32'(bus8.d), 32'h05);

        // Asynchronous reset three cycles into an operation.
        @(negedge clk);
        bus8.a     = 8'h33;
        bus8.b     = 8'h11;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(bus8.busy), 32'd0);
        check("mid reset done", 32'(bus8.done), 32'd0);
        check("mid reset d", 32'(bus8.d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus8.done) seen_done++;
        end
        check("no done after reset", 32'(seen_done), 32'd0);
        run8("after reset 33-11", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

        // 8-bit, 4-bit digits
        @(negedge clk);
        bus84.a     = 8'h3C;
        bus84.b     = 8'h4D;
        bus84.bin   = 1'b0;
        bus84.start = 1'b1;
        @(posedge clk);
        #1;
        bus84.start = 1'b0;
        lat = 0;
        while (!bus84.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("d4 latency", 32'(lat), 32'd2);
        check("d4 d", 32'(bus84.d), 32'hEF);
        check("d4 bout", 32'(bus84.bout), 32'd1);
        check("d4 ovf", 32'(bus84.ovf), 32'd0);

        // 16-bit, single digit
        @(negedge clk);
        bus16.a     = 16'h8000;
        bus16.b     = 16'h0001;
        bus16.bin   = 1'b0;
        bus16.start = 1'b1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        lat = 0;
        while (!bus16.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("d16 latency", 32'(lat), 32'd1);
        check("d16 d", 32'(bus16.d), 32'h7FFF);
        check("d16 bout", 32'(bus16.bout), 32'd0);
        check("d16 ovf", 32'(bus16.ovf), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
